// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station: dispatch buffer, wakeup capture, single-op issue select
// Optional RS_AGE_ORDER_EN: issue the oldest ready entry by dispatch order instead of the lowest-index one.
module reservation_station #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int ROB_W = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [3:0]              dispatch_ALUControl,
  input  logic                    dispatch_ALUSrc,
  input  logic                    dispatch_is_for_lsq,
  input  logic [31:0]             dispatch_imm,
  input  logic [TAG_W-1:0]        dispatch_rs1_tag,
  input  logic [TAG_W-1:0]        dispatch_rs2_tag,
  input  logic                    dispatch_rs1_ready,
  input  logic                    dispatch_rs2_ready,
  input  logic [31:0]             dispatch_rs1_value,
  input  logic [31:0]             dispatch_rs2_value,
  input  logic [TAG_W-1:0]        dispatch_dest_tag,
  input  logic [ROB_W-1:0]        dispatch_rob_index,
  input  logic                    wakeup_active,
  input  logic [TAG_W-1:0]        wakeup_tag,
  input  logic [31:0]             wakeup_value,
  input  logic                    fu_is_available,
  output logic                    fu_write_enable,
  output logic [3:0]              fu_ALUControl,
  output logic                    fu_ALUSrc,
  output logic                    fu_is_for_lsq,
  output logic [31:0]             fu_imm,
  output logic [31:0]             fu_rs1_value,
  output logic [31:0]             fu_rs2_value,
  output logic [TAG_W-1:0]        fu_tag_to_output,
  output logic [ROB_W-1:0]        fu_rob_index,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [DEPTH-1:0] r_valid, r_rs1_rdy, r_rs2_rdy, r_src, r_lsq;
  logic [3:0]       r_ctrl    [DEPTH];
  logic [31:0]      r_imm     [DEPTH];
  logic [31:0]      r_rs1_val [DEPTH];
  logic [31:0]      r_rs2_val [DEPTH];
  logic [TAG_W-1:0] r_rs1_tag [DEPTH];
  logic [TAG_W-1:0] r_rs2_tag [DEPTH];
  logic [TAG_W-1:0] r_dest    [DEPTH];
  logic [ROB_W-1:0] r_rob     [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0] w_rdy;
  logic             w_any, w_disp, w_issue;
  logic [IDX_W-1:0] w_sel, w_free;
  logic             w_d_rs1_rdy, w_d_rs2_rdy;
  logic [31:0]      w_d_rs1_val, w_d_rs2_val;

  assign w_rdy           = r_valid & r_rs1_rdy & r_rs2_rdy;
  assign w_any           = |w_rdy;
  assign dispatch_ready  = (r_occ < DEPTH_C);
  assign w_disp          = dispatch_valid && dispatch_ready;
  assign w_issue         = fu_is_available && w_any;
  assign fu_write_enable = w_issue;
  assign occupancy       = r_occ;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    w_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_valid[i]) w_free = IDX_W'(i);
  end

`ifdef RS_AGE_ORDER_EN
  // Ages are a dense 0..occupancy-1 ranking; 0 is the oldest live entry.
  logic [IDX_W-1:0] r_age [DEPTH];
  logic [IDX_W-1:0] w_best;

  always_comb begin
    w_sel  = '0;
    w_best = '1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (w_rdy[i] && r_age[i] <= w_best) begin
        w_sel  = IDX_W'(i);
        w_best = r_age[i];
      end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_issue && r_valid[i] && r_age[i] > r_age[w_sel]) r_age[i] <= r_age[i] - 1'b1;
      if (w_disp) r_age[w_free] <= IDX_W'(r_occ - OCC_W'(w_issue));
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (w_rdy[i]) w_sel = IDX_W'(i);
  end
`endif

  // Same-cycle wakeup bypass for operands arriving with the dispatch.
  always_comb begin
    w_d_rs1_rdy = dispatch_rs1_ready;
    w_d_rs1_val = dispatch_rs1_value;
    w_d_rs2_rdy = dispatch_rs2_ready || dispatch_ALUSrc;
    w_d_rs2_val = dispatch_rs2_value;
    if (!w_d_rs1_rdy && wakeup_active && wakeup_tag == dispatch_rs1_tag) begin
      w_d_rs1_rdy = 1'b1;
      w_d_rs1_val = wakeup_value;
    end
    if (!w_d_rs2_rdy && wakeup_active && wakeup_tag == dispatch_rs2_tag) begin
      w_d_rs2_rdy = 1'b1;
      w_d_rs2_val = wakeup_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= '0;
      r_rs1_rdy <= '0;
      r_rs2_rdy <= '0;
      r_src     <= '0;
      r_lsq     <= '0;
      r_occ     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i]    <= '0;
        r_imm[i]     <= '0;
        r_rs1_val[i] <= '0;
        r_rs2_val[i] <= '0;
        r_rs1_tag[i] <= '0;
        r_rs2_tag[i] <= '0;
        r_dest[i]    <= '0;
        r_rob[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wakeup_active && r_valid[i] && !r_rs1_rdy[i] && r_rs1_tag[i] == wakeup_tag) begin
          r_rs1_rdy[i] <= 1'b1;
          r_rs1_val[i] <= wakeup_value;
        end
        if (wakeup_active && r_valid[i] && !r_rs2_rdy[i] && r_rs2_tag[i] == wakeup_tag) begin
          r_rs2_rdy[i] <= 1'b1;
          r_rs2_val[i] <= wakeup_value;
        end
      end
      if (w_issue) r_valid[w_sel] <= 1'b0;
      if (w_disp) begin
        r_valid[w_free]   <= 1'b1;
        r_ctrl[w_free]    <= dispatch_ALUControl;
        r_src[w_free]     <= dispatch_ALUSrc;
        r_lsq[w_free]     <= dispatch_is_for_lsq;
        r_imm[w_free]     <= dispatch_imm;
        r_rs1_tag[w_free] <= dispatch_rs1_tag;
        r_rs2_tag[w_free] <= dispatch_rs2_tag;
        r_rs1_rdy[w_free] <= w_d_rs1_rdy;
        r_rs2_rdy[w_free] <= w_d_rs2_rdy;
        r_rs1_val[w_free] <= w_d_rs1_val;
        r_rs2_val[w_free] <= w_d_rs2_val;
        r_dest[w_free]    <= dispatch_dest_tag;
        r_rob[w_free]     <= dispatch_rob_index;
      end
      r_occ <= r_occ + OCC_W'(w_disp) - OCC_W'(w_issue);
    end
  end

  always_comb begin
    fu_ALUControl    = '0;
    fu_ALUSrc        = 1'b0;
    fu_is_for_lsq    = 1'b0;
    fu_imm           = '0;
    fu_rs1_value     = '0;
    fu_rs2_value     = '0;
    fu_tag_to_output = '0;
    fu_rob_index     = '0;
    if (w_any) begin
      fu_ALUControl    = r_ctrl[w_sel];
      fu_ALUSrc        = r_src[w_sel];
      fu_is_for_lsq    = r_lsq[w_sel];
      fu_imm           = r_imm[w_sel];
      fu_rs1_value     = r_rs1_val[w_sel];
      fu_rs2_value     = r_rs2_val[w_sel];
      fu_tag_to_output = r_dest[w_sel];
      fu_rob_index     = r_rob[w_sel];
    end
  end

  always_ff @(posedge clk) begin
    assert (!(reset_n && dispatch_valid && !dispatch_ready))
      else $fatal(1, "reservation_station: dispatch while full");
  end
endmodule
